// File: rtl/load_store_unit_if.sv
// Signal bundles for the load/store unit. lsu_req_if carries requests from the execute stage.
// lsu_mem_if carries word accesses to the block RAM.
interface lsu_req_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  is_store;
    logic [1:0]            size;
    logic                  sign_extend;
    logic                  byte_reverse;
    logic [ADDR_WIDTH-1:0] address;
    logic [31:0]           store_data;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [31:0]           load_data;

    modport master (
        output start, is_store, size, sign_extend, byte_reverse, address, store_data,
        input  busy, done, error, load_data
    );
    modport slave (
        input  start, is_store, size, sign_extend, byte_reverse, address, store_data,
        output busy, done, error, load_data
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [31:0]           mem_data_out;
    logic [3:0]            mem_write_mask;
    logic                  mem_write_enable;
    logic [31:0]           mem_data_in;

    modport master (
        output mem_address, mem_data_out, mem_write_mask, mem_write_enable,
        input  mem_data_in
    );
    modport slave (
        input  mem_address, mem_data_out, mem_write_mask, mem_write_enable,
        output mem_data_in
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word requests, including byte-reversed forms,
// into single word accesses on a big-endian 4-lane RAM with active-low lane masks.
module load_store_unit #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    typedef enum logic [1:0] {IDLE, ACCESS, READ_WAIT, FINISH} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    state_t                r_state, w_next_state;
    logic                  r_is_store;
    logic [1:0]            r_size;
    logic                  r_sign_extend;
    logic                  r_byte_reverse;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [31:0]           r_store_data;
    logic                  r_error_pending;
    logic                  r_done;
    logic                  r_error;
    logic [31:0]           r_load_data;

    logic                  w_misaligned;
    logic [1:0]            w_offset;
    logic [15:0]           w_store_half;
    logic [31:0]           w_store_lanes;
    logic [3:0]            w_store_mask;
    logic [7:0]            w_load_byte;
    logic [15:0]           w_load_half;
    logic [31:0]           w_load_result;

    function automatic logic [15:0] swap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    assign w_offset = r_address[1:0];

    always_comb begin
        w_misaligned = (req.size == 2'd3)
                    || (req.size == 2'd1 && req.address[0])
                    || (req.size == 2'd2 && (|req.address[1:0]));
    end

    // Store data is replicated across lanes so the mask alone selects what lands.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_store_half  = r_byte_reverse ? swap16(r_store_data[15:0]) : r_store_data[15:0];
        w_store_lanes = r_byte_reverse ? swap32(r_store_data) : r_store_data;
        w_store_mask  = 4'b0000;
        case (r_size)
            SIZE_BYTE: begin
                w_store_lanes = {4{r_store_data[7:0]}};
                w_store_mask  = ~(4'b1000 >> w_offset);
            end
            SIZE_HALF: begin
                w_store_lanes = {2{w_store_half}};
                w_store_mask  = w_offset[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_load_byte = mem.mem_data_in[7:0];
        case (w_offset)
            2'd0:    w_load_byte = mem.mem_data_in[31:24];
            2'd1:    w_load_byte = mem.mem_data_in[23:16];
            2'd2:    w_load_byte = mem.mem_data_in[15:8];
            default: w_load_byte = mem.mem_data_in[7:0];
        endcase
        w_load_half = w_offset[1] ? mem.mem_data_in[15:0] : mem.mem_data_in[31:16];
        if (r_byte_reverse) begin
            w_load_half = swap16(w_load_half);
        end
        case (r_size)
            SIZE_BYTE: w_load_result = {{24{r_sign_extend & w_load_byte[7]}}, w_load_byte};
            SIZE_HALF: w_load_result = {{16{r_sign_extend & w_load_half[15]}}, w_load_half};
            default:   w_load_result = r_byte_reverse ? swap32(mem.mem_data_in) : mem.mem_data_in;
        endcase
    end

    always_comb begin
        w_next_state         = r_state;
        mem.mem_address      = '0;
        mem.mem_data_out     = '0;
        mem.mem_write_mask   = 4'hf;
        mem.mem_write_enable = 1'b0;
        case (r_state)
            IDLE: begin
                if (req.start) begin
                    w_next_state = w_misaligned ? FINISH : ACCESS;
                end
            end
            ACCESS: begin
                mem.mem_address = {r_address[ADDR_WIDTH-1:2], 2'b00};
                if (r_is_store) begin
                    mem.mem_write_enable = 1'b1;
                    mem.mem_data_out     = w_store_lanes;
                    mem.mem_write_mask   = w_store_mask;
                    w_next_state         = FINISH;
                end else begin
                    w_next_state = READ_WAIT;
                end
            end
            READ_WAIT: w_next_state = FINISH;
            default:   w_next_state = IDLE;
        endcase
    end

    // done/error are registered off FINISH, so they appear in the cycle after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state == FINISH);
            r_error <= (r_state == FINISH) && r_error_pending;
            if (r_state == READ_WAIT) begin
                r_load_data <= w_load_result;
            end
        end
    end

    // NOTE: request latches carry no reset; they are always written before FINISH reads them.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && req.start) begin
            r_is_store      <= req.is_store;
            r_size          <= req.size;
            r_sign_extend   <= req.sign_extend;
            r_byte_reverse  <= req.byte_reverse;
            r_address       <= req.address;
            r_store_data    <= req.store_data;
            r_error_pending <= w_misaligned;
        end
    end

    assign req.busy      = (r_state != IDLE) || r_done;
    assign req.done      = r_done;
    assign req.error     = r_error;
    assign req.load_data = r_load_data;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written corner sequences,
// and random traffic checked against a byte-addressed big-endian memory model.
module tb_load_store_unit;
    localparam int AW = 12;

    typedef struct {
        logic          st;
        logic [1:0]    sz;
        logic          sx;
        logic          rv;
        logic [AW-1:0] addr;
        logic [31:0]   wd;
        logic          exp_err;
        logic [31:0]   exp_ld;
        logic [3:0]    exp_mask;
        logic [31:0]   exp_dout;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_last;
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] ram [0:1023];
    logic [31:0] ram_q;
    vec_t        vecs [23];

    lsu_req_if #(.ADDR_WIDTH(AW)) req ();
    lsu_mem_if #(.ADDR_WIDTH(AW)) mem ();

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .mem   (mem)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in: registered read, active-low lane write mask.
    always @(posedge clk) begin : ram_model
        logic [31:0] merged;
        merged = ram[mem.mem_address[AW-1:2]];
        if (mem.mem_write_enable) begin
            for (int l = 0; l < 4; l++) begin
                if (!mem.mem_write_mask[l]) merged[8*l +: 8] = mem.mem_data_out[8*l +: 8];
            end
            ram[mem.mem_address[AW-1:2]] <= merged;
        end
        ram_q <= ram[mem.mem_address[AW-1:2]];
    end
    assign mem.mem_data_in = ram_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: memory as a flat byte array, byte at offset 0 is most significant.
    task automatic model_op(input logic st, input logic [1:0] sz, input logic sx, input logic rv,
                            input logic [AW-1:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] ld, output logic [3:0] msk,
                            output logic [31:0] dout, output logic [31:0] lanes);
        int          n;
        int          idx;
        int          lane;
        logic [7:0]  b;
        logic [31:0] v;
        err   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        n     = 1 << sz;
        ld    = exp_last;
        msk   = 4'hf;
        dout  = '0;
        lanes = '0;
        if (err) return;
        if (st) begin
            for (int i = 0; i < n; i++) begin
                b            = rv ? wd[8*i +: 8] : wd[8*(n-1-i) +: 8];
                idx          = int'(a) + i;
                ref_mem[idx] = b;
                lane         = idx % 4;
                msk[3-lane]  = 1'b0;
                dout[31-8*lane -: 8]  = b;
                lanes[31-8*lane -: 8] = 8'hff;
            end
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                b = ref_mem[int'(a) + i];
                if (rv) v = v | (32'(b) << (8*i));
                else    v = (v << 8) | 32'(b);
            end
            if (sx && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            ld       = v;
            exp_last = v;
        end
    endtask

    task automatic run_op(input logic st, input logic [1:0] sz, input logic sx, input logic rv,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output int wes, output logic [3:0] msk,
                          output logic [31:0] dout, output logic [AW-1:0] wa,
                          output logic [31:0] ld, output logic hs_ok);
        lat = -1; err = 1'b0; wes = 0; msk = 4'hf; dout = '0; wa = '0; ld = '0; hs_ok = 1'b1;
        @(negedge clk);
        req.start = 1'b1; req.is_store = st; req.size = sz; req.sign_extend = sx;
        req.byte_reverse = rv; req.address = a; req.store_data = wd;
        @(posedge clk);
        #1 req.start = 1'b0;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(negedge clk);
            if (mem.mem_write_enable) begin
                wes++;
                msk  = mem.mem_write_mask;
                dout = mem.mem_data_out;
                wa   = mem.mem_address;
            end
            if (!req.busy) hs_ok = 1'b0;
            if (req.done) begin
                lat = c;
                err = req.error;
                ld  = req.load_data;
            end
        end
        @(negedge clk);
        if (req.done || req.busy || mem.mem_write_enable || mem.mem_write_mask != 4'hf) hs_ok = 1'b0;
    endtask

    task automatic exec_op(input string tag, input logic st, input logic [1:0] sz, input logic sx,
                           input logic rv, input logic [AW-1:0] a, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_ld, input logic [3:0] exp_mask,
                           input logic [31:0] exp_dout, input logic [31:0] lane_sel);
        int            lat;
        int            wes;
        logic          err;
        logic          hs_ok;
        logic [3:0]    msk;
        logic [31:0]   dout;
        logic [31:0]   ld;
        logic [AW-1:0] wa;
        run_op(st, sz, sx, rv, a, wd, lat, err, wes, msk, dout, wa, ld, hs_ok);
        check($sformatf("%s latency", tag), lat, exp_err ? 2 : (st ? 3 : 4));
        check($sformatf("%s error", tag), 32'(err), 32'(exp_err));
        check($sformatf("%s write_count", tag), wes, (st && !exp_err) ? 1 : 0);
        check($sformatf("%s busy_window", tag), 32'(hs_ok), 32'd1);
        if (st && !exp_err) begin
            check($sformatf("%s mask", tag), 32'(msk), 32'(exp_mask));
            check($sformatf("%s data_out", tag), dout & lane_sel, exp_dout & lane_sel);
            check($sformatf("%s mem_address", tag), 32'(wa), 32'({a[AW-1:2], 2'b00}));
        end else begin
            check($sformatf("%s load_data", tag), ld, exp_ld);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin : main
        logic          m_err;
        logic [31:0]   m_ld;
        logic [3:0]    m_msk;
        logic [31:0]   m_dout;
        logic [31:0]   m_lanes;
        logic          r_st;
        logic [1:0]    r_sz;
        logic [AW-1:0] r_a;
        int            dones;
        int            wes;
        logic [31:0]   seen_ld;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 1'b0, 12'h010, 32'h0,        1'b0, 32'hDEADBEEF, 4'hf,    32'h0};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 1'b0, 12'h020, 32'h11,       1'b0, 32'h0,        4'b0111, 32'h11111111};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 1'b0, 12'h021, 32'h22,       1'b0, 32'h0,        4'b1011, 32'h22222222};
        vecs[4]  = '{1'b1, 2'd0, 1'b0, 1'b0, 12'h022, 32'h33,       1'b0, 32'h0,        4'b1101, 32'h33333333};
        vecs[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 12'h023, 32'h44,       1'b0, 32'h0,        4'b1110, 32'h44444444};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 1'b0, 12'h020, 32'h0,        1'b0, 32'h11223344, 4'hf,    32'h0};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 12'h022, 32'h0,        1'b0, 32'h00000033, 4'hf,    32'h0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 1'b0, 12'h030, 32'h000080F0, 1'b0, 32'h0,        4'b0000, 32'h000080F0};
        vecs[9]  = '{1'b0, 2'd1, 1'b1, 1'b0, 12'h032, 32'h0,        1'b0, 32'hFFFF80F0, 4'hf,    32'h0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 1'b0, 12'h032, 32'h0,        1'b0, 32'h000080F0, 4'hf,    32'h0};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 12'h033, 32'h0,        1'b0, 32'hFFFFFFF0, 4'hf,    32'h0};
        vecs[12] = '{1'b1, 2'd2, 1'b0, 1'b1, 12'h040, 32'h12345678, 1'b0, 32'h0,        4'b0000, 32'h78563412};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 1'b0, 12'h040, 32'h0,        1'b0, 32'h78563412, 4'hf,    32'h0};
        vecs[14] = '{1'b0, 2'd1, 1'b0, 1'b1, 12'h040, 32'h0,        1'b0, 32'h00005678, 4'hf,    32'h0};
        vecs[15] = '{1'b1, 2'd1, 1'b0, 1'b1, 12'h046, 32'h0000ABCD, 1'b0, 32'h0,        4'b1100, 32'hCDABCDAB};
        vecs[16] = '{1'b0, 2'd2, 1'b0, 1'b0, 12'h044, 32'h0,        1'b0, 32'h0000CDAB, 4'hf,    32'h0};
        vecs[17] = '{1'b0, 2'd2, 1'b0, 1'b0, 12'h041, 32'h0,        1'b1, 32'h0000CDAB, 4'hf,    32'h0};
        vecs[18] = '{1'b1, 2'd1, 1'b0, 1'b0, 12'h043, 32'h5555,     1'b1, 32'h0000CDAB, 4'hf,    32'h0};
        vecs[19] = '{1'b0, 2'd3, 1'b0, 1'b0, 12'h040, 32'h0,        1'b1, 32'h0000CDAB, 4'hf,    32'h0};
        vecs[20] = '{1'b1, 2'd1, 1'b0, 1'b0, 12'h050, 32'h00001234, 1'b0, 32'h0,        4'b0011, 32'h12341234};
        vecs[21] = '{1'b0, 2'd2, 1'b0, 1'b0, 12'h050, 32'h0,        1'b0, 32'h12340000, 4'hf,    32'h0};
        vecs[22] = '{1'b0, 2'd2, 1'b0, 1'b1, 12'h020, 32'h0,        1'b0, 32'h44332211, 4'hf,    32'h0};

        reset = 1'b1;
        req.start = 1'b0; req.is_store = 1'b0; req.size = 2'd0; req.sign_extend = 1'b0;
        req.byte_reverse = 1'b0; req.address = '0; req.store_data = '0;
        exp_last = '0;
        ram_q = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset busy", 32'(req.busy), 32'd0);
        check("reset done", 32'(req.done), 32'd0);
        check("reset error", 32'(req.error), 32'd0);
        check("reset load_data", req.load_data, 32'd0);
        check("reset write_enable", 32'(mem.mem_write_enable), 32'd0);
        check("reset write_mask", 32'(mem.mem_write_mask), 32'hf);
        check("reset mem_address", 32'(mem.mem_address), 32'd0);
        check("reset mem_data_out", mem.mem_data_out, 32'd0);

        for (int i = 0; i < 23; i++) begin
            model_op(vecs[i].st, vecs[i].sz, vecs[i].sx, vecs[i].rv, vecs[i].addr, vecs[i].wd,
                     m_err, m_ld, m_msk, m_dout, m_lanes);
            exec_op($sformatf("vec%0d", i), vecs[i].st, vecs[i].sz, vecs[i].sx, vecs[i].rv,
                    vecs[i].addr, vecs[i].wd, vecs[i].exp_err, vecs[i].exp_ld,
                    vecs[i].exp_mask, vecs[i].exp_dout, 32'hFFFFFFFF);
        end

        // start held high while busy, with a store request on the bus: must be ignored.
        model_op(1'b0, 2'd2, 1'b0, 1'b0, 12'h020, 32'h0, m_err, m_ld, m_msk, m_dout, m_lanes);
        @(negedge clk);
        req.start = 1'b1; req.is_store = 1'b0; req.size = 2'd2; req.sign_extend = 1'b0;
        req.byte_reverse = 1'b0; req.address = 12'h020; req.store_data = '0;
        @(posedge clk);
        dones = 0; wes = 0; seen_ld = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req.done) begin
                dones++;
                seen_ld = req.load_data;
            end
            if (mem.mem_write_enable) wes++;
            if (c < 4) begin
                req.start = 1'b1; req.is_store = 1'b1; req.address = 12'h060;
                req.store_data = 32'hA5A5A5A5;
            end else begin
                req.start = 1'b0;
            end
        end
        check("busy_start done_count", dones, 1);
        check("busy_start write_count", wes, 0);
        check("busy_start load_data", seen_ld, m_ld);

        // Reset landing on the READ_WAIT edge aborts the load.
        @(negedge clk);
        req.start = 1'b1; req.is_store = 1'b0; req.size = 2'd2; req.address = 12'h010;
        @(posedge clk);
        #1 req.start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort busy", 32'(req.busy), 32'd0);
        check("abort done", 32'(req.done), 32'd0);
        check("abort write_mask", 32'(mem.mem_write_mask), 32'hf);
        check("abort write_enable", 32'(mem.mem_write_enable), 32'd0);
        check("abort load_data", req.load_data, 32'd0);
        exp_last = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (req.done) dones++;
        end
        check("abort no_done", dones, 0);

        for (int k = 0; k < 160; k++) begin
            r_st = 1'($urandom_range(0, 1));
            r_sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_a  = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (r_sz == 2'd1) r_a[0] = 1'b0;
                if (r_sz == 2'd2) r_a[1:0] = 2'b00;
            end
            exec_op_random(k, r_st, r_sz, r_a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    task automatic exec_op_random(input int k, input logic st, input logic [1:0] sz,
                                  input logic [AW-1:0] a);
        logic        sx;
        logic        rv;
        logic [31:0] wd;
        logic        m_err;
        logic [31:0] m_ld;
        logic [3:0]  m_msk;
        logic [31:0] m_dout;
        logic [31:0] m_lanes;
        sx = 1'($urandom_range(0, 1));
        rv = 1'($urandom_range(0, 1));
        wd = $urandom;
        model_op(st, sz, sx, rv, a, wd, m_err, m_ld, m_msk, m_dout, m_lanes);
        exec_op($sformatf("rnd%0d", k), st, sz, sx, rv, a, wd, m_err, m_ld, m_msk, m_dout, m_lanes);
    endtask
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory initiator between the PowerPC core's execute stage and the 4 KB block RAM (1024 words × 4 byte lanes).
- Converts byte, halfword and word loads/stores, including byte-reversed forms (lhbrx/lwbrx/sthbrx/stwbrx), into RAM word accesses:
  - stores use per-lane active-low write masks;
  - loads extract and optionally sign-extend the result (lha).
- Memory is big-endian: the byte at address offset 0 occupies data bits [31:24].

Parameters:
- ADDR_WIDTH, 12, byte address width; the RAM word index is address[ADDR_WIDTH-1:2].

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is reserved and treated as an error.
- sign_extend  input  1  loads only: sign-extend a byte/halfword result.
- byte_reverse  input  1  halfword/word only: reverse byte order of data.
- address  input  ADDR_WIDTH  byte address.
- store_data  input  32  store value, right-justified.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- error  output  1  valid with done: misaligned access or reserved size.
- load_data  output  32  load result, valid with done and held until the next load completes.
- mem_address  output  ADDR_WIDTH  to RAM address.
- mem_data_out  output  32  to RAM data_in.
- mem_write_mask  output  4  to RAM write_mask; active-low per lane; bit 3 = offset 0 = bits [31:24].
- mem_write_enable  output  1  to RAM write_enable.
- mem_data_in  input  32  from RAM data_out; registered, valid one cycle after a read address is presented.

Behaviour:
- Reset values:
  - state = IDLE; busy = 0; done = 0; error = 0; load_data = 0.
  - mem_write_enable = 0; mem_write_mask = 4'hf; mem_address = 0; mem_data_out = 0.
- States: IDLE, ACCESS, READ_WAIT, FINISH.
- IDLE:
  - On start, latch all request inputs.
  - If misaligned (halfword with address[0]=1; word with address[1:0]!=0; size=3), go to FINISH with error=1. No memory cycle; mem_write_enable stays 0.
  - Otherwise go to ACCESS.
  - start is ignored in all other states.
- ACCESS (one cycle):
  - mem_address = latched address, low 2 bits forced to 0.
  - Store:
    - mem_write_enable=1.
    - Data is replicated into lanes by offset: byte → all lanes = store_data[7:0]; halfword → both halves = store_data[15:0] (byte-swapped first if byte_reverse); word → store_data (byte-reversed if byte_reverse).
    - Mask clears only the target lanes:
      - byte at offset k → only mask bit (3-k) = 0;
      - halfword at offset 0 → 4'b0011; at offset 2 → 4'b1100;
      - word → 4'b0000.
    - Next state FINISH.
  - Load: mem_write_enable=0, mask=4'hf; next state READ_WAIT.
- READ_WAIT (one cycle):
  - Select target lanes from mem_data_in by offset and apply byte_reverse.
  - Zero-extend, or sign-extend when sign_extend=1 (byte: bit 7; halfword: bit 15). sign_extend is ignored for words.
  - Register the result into load_data. Next state FINISH.
- FINISH:
  - done=1 for exactly one cycle; error valid; mem_write_enable=0, mask=4'hf; next state IDLE.
  - start may be accepted again in the IDLE cycle that follows.
- Latency, counting the start cycle as cycle 0:
  - store: done in cycle 3;
  - load: done in cycle 4;
  - error: done in cycle 2.
- busy: high from cycle 1 through the done cycle.
- mem_write_enable is high for exactly one clock per store, never for loads or errors.
- Reset mid-operation:
  - Returns to IDLE on that edge and drives the reset values. No done pulse for the aborted request.
  - A store already in ACCESS on the reset edge may have been written; no later write occurs.
- Address wrap: none; word index = address[ADDR_WIDTH-1:2].

Test Plan:
- Word store at address 0x010 with store_data 0xDEADBEEF → one cycle with mem_write_enable=1, mem_address 0x010, mask 4'b0000, data 0xDEADBEEF. Then load word at 0x010 → load_data 0xDEADBEEF, done in cycle 4, error 0.
- Byte stores 0x11, 0x22, 0x33, 0x44 to 0x020–0x023 → masks 4'b0111, 1011, 1101, 1110 in order. Word load at 0x020 → 0x11223344. Byte load at 0x022 → 0x00000033.
- RAM word 0x000080F0 at 0x030:
  - halfword load at 0x032 with sign_extend=1 → 0xFFFF80F0; with sign_extend=0 → 0x000080F0;
  - byte load at 0x033 with sign_extend=1 → 0xFFFFFFF0.
- byte_reverse:
  - stwbrx 0x12345678 at 0x040, then plain word load → 0x78563412;
  - lhbrx at 0x040 → 0x00005678;
  - sthbrx 0xABCD at 0x046 → mask 4'b1100, word at 0x044 bits [15:0] = 0xCDAB.
- Misaligned: word load at 0x041, halfword store at 0x043, size=3 → done in cycle 2 with error=1; mem_write_enable never asserted; load_data unchanged.
- Assert reset during READ_WAIT → done never pulses; busy=0 and mask 4'hf on the next cycle. start pulsed while busy → ignored, exactly one done per accepted request.
